sprite_mixer: RTL and testbench
===============================

// Module: sprite_mixer
// PURPOSE
//  N-channel sprite compositor that sits between the sprite instances and vga_bitchange.
//  Replaces the hard-wired two-sprite OR/ternary mux with a parametrised, registered priority mixer.
//  - Colour index 0 is transparent for every channel.
//  - Adds per-frame sprite-to-sprite collision detection for game logic (duck/obstacle hits).
// PARAMETERS
//  NSPR   4          number of sprite channels (1..16)
//  CIDXW  2          colour-index width per channel
//  IDW    $clog2(NSPR) (min 1)  width of winning-channel id
//  CNTW   8          width of collision-frame counter
// PORTS
//  clk          in   1           pixel clock (clk25 domain)
//  rst_n        in   1           asynchronous reset, active-low
//  frame        in   1           1-cycle pulse, first pixel of each frame
//  bright       in   1           active-video qualifier from display_controller
//  spr_en       in   NSPR        per-channel enable; bit i gates channel i
//  spr_drawing  in   NSPR        per-channel drawing flag from sprite instances
//  spr_pix      in   NSPR*CIDXW  channel i index at [i*CIDXW +: CIDXW]
//  pix          out  CIDXW       composited colour index (0 = background)
//  drawing      out  1           any opaque sprite at this pixel
//  hit_id       out  IDW         channel that won the pixel (0 when drawing=0)
//  coll_vec     out  NSPR        channels that collided during the previous frame
//  coll_any     out  1           |coll_vec
//  coll_cnt     out  CNTW        frames with >=1 collision since reset, saturating
// BEHAVIOUR
//  - Reset: all outputs 0; internal accumulator coll_acc = 0.
//  - opaque[i] = spr_en[i] & spr_drawing[i] & (spr_pix[i] != 0) & bright.
//  - Priority: lowest index opaque channel wins (channel 0 on top).
//  - Latency: exactly 1 clk, inputs sampled at cycle t -> pix/drawing/hit_id valid at t+1.
//    Caller delays hc/vc-derived bright by 1 (SX_OFFS accounts for this).
//  - No opaque channel: pix=0, drawing=0, hit_id=0 next cycle.
//  - bright=0: treated as no opaque channel; no collision accumulation.
//  - Collision cycle: popcount(opaque) >= 2 -> coll_acc |= opaque.
//    A single opaque channel never sets a bit.
//  - Frame pulse (frame=1):
//    - coll_vec <= coll_acc (prior frame only).
//    - coll_acc <= collision bits of the current cycle (not dropped, not double-counted).
//    - coll_cnt <= coll_cnt + 1 if coll_acc != 0.
//      Saturates at 2^CNTW-1, never wraps.
//  - coll_vec/coll_any/coll_cnt change only on frame cycles (and at reset).
//    Stable for the whole following frame.
//  - spr_en change mid-frame: takes effect on the next sample.
//    Bits already in coll_acc are kept.
//  - Reset asserted mid-frame: everything clears asynchronously.
//    First frame pulse after release reports coll_vec = 0.
//  - Widths: popcount width $clog2(NSPR+1); comparisons unsigned.
//  - Compositor fully combinational before the single output register; no multicycle paths.
// CONFIGURATION
//  SPRITE_MIXER_COLLIDE_EN
//  - Defined: collision logic above is built.
//  - Undefined: coll_acc/popcount/counter not instantiated.
//    coll_vec, coll_any, coll_cnt tied to 0.
//    Compositor path and latency unchanged.
// TESTING
//  1. Reset: rst_n=0 with random inputs -> all outputs 0; release, no sprites -> pix=0, drawing=0.
//  2. Priority: NSPR=4, ch1 pix=2 and ch3 pix=1 opaque, bright=1 at t
//     -> t+1: pix=2, drawing=1, hit_id=1.
//  3. Transparency/enable:
//     - ch0 drawing with pix=0 plus ch2 pix=3 -> pix=3, hit_id=2.
//     - Clear spr_en[2] -> pix=0, drawing=0 next cycle.
//  4. Collision: ch0 and ch2 overlap 5 pixels in frame N, ch1 alone elsewhere.
//     - At frame N+1 pulse: coll_vec=4'b0101, coll_any=1, coll_cnt=1.
//     - Clean frame N+1 -> next pulse coll_vec=0, coll_cnt stays 1.
//  5. Edge cases:
//     - Overlap exactly on the frame-pulse cycle -> counted in the new frame, not the old one.
//     - Overlap with bright=0 -> ignored.
//     - Force 300 colliding frames with CNTW=8 -> coll_cnt holds 255.
//  6. Build without SPRITE_MIXER_COLLIDE_EN, repeat test 4:
//     - coll_* stay 0.
//     - Test 2 results identical.

Source files
------------

// File: rtl/sprite_mixer.sv
// N-channel registered priority sprite compositor with per-frame collision reporting.
// Collision logic is built only when SPRITE_MIXER_COLLIDE_EN is defined.
module sprite_mixer #(
    parameter int unsigned NSPR  = 4,
    parameter int unsigned CIDXW = 2,
    parameter int unsigned IDW   = (NSPR > 1) ? $clog2(NSPR) : 1,
    parameter int unsigned CNTW  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame,
    input  logic                   bright,
    input  logic [NSPR-1:0]        spr_en,
    input  logic [NSPR-1:0]        spr_drawing,
    input  logic [NSPR*CIDXW-1:0]  spr_pix,
    output logic [CIDXW-1:0]       pix,
    output logic                   drawing,
    output logic [IDW-1:0]         hit_id,
    output logic [NSPR-1:0]        coll_vec,
    output logic                   coll_any,
    output logic [CNTW-1:0]        coll_cnt
);

    logic [NSPR-1:0]  w_opaque;
    logic [CIDXW-1:0] w_win_pix;
    logic [IDW-1:0]   w_win_id;
    logic             w_any;

    logic [CIDXW-1:0] r_pix;
    logic             r_drawing;
    logic [IDW-1:0]   r_hit_id;

    // A channel is opaque only when enabled, drawing, non-transparent and in active video.
    always_comb begin
        w_opaque = '0;
        for (int i = 0; i < int'(NSPR); i++) begin
            w_opaque[i] = spr_en[i] & spr_drawing[i] & bright
                        & (spr_pix[i*CIDXW +: CIDXW] != '0);
        end
    end

    // Lowest-index opaque channel sits on top.
    always_comb begin
        w_win_pix = '0;
        w_win_id  = '0;
        w_any     = 1'b0;
        for (int i = 0; i < int'(NSPR); i++) begin
            if (w_opaque[i] && !w_any) begin
                w_win_pix = spr_pix[i*CIDXW +: CIDXW];
                w_win_id  = IDW'(i);
                w_any     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix     <= '0;
            r_drawing <= 1'b0;
            r_hit_id  <= '0;
        end else begin
            r_pix     <= w_win_pix;
            r_drawing <= w_any;
            r_hit_id  <= w_win_id;
        end
    end

    assign pix     = r_pix;
    assign drawing = r_drawing;
    assign hit_id  = r_hit_id;

`ifdef SPRITE_MIXER_COLLIDE_EN
    localparam int unsigned PCW = $clog2(NSPR + 1);

    logic [PCW-1:0]  w_popcnt;
    logic [NSPR-1:0] w_coll;

    logic [NSPR-1:0] r_coll_acc;
    logic [NSPR-1:0] r_coll_vec;
    logic            r_coll_any;
    logic [CNTW-1:0] r_coll_cnt;

    // Compare in 32 bits so a 1-bit popcount (NSPR=1) never aliases the threshold of 2.
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < int'(NSPR); i++) begin
            w_popcnt = w_popcnt + PCW'(w_opaque[i]);
        end
        w_coll = (32'(w_popcnt) >= 32'd2) ? w_opaque : '0;
    end

    // On a frame pulse the current cycle's collisions open the new accumulation window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coll_acc <= '0;
            r_coll_vec <= '0;
            r_coll_any <= 1'b0;
            r_coll_cnt <= '0;
        end else if (frame) begin
            r_coll_vec <= r_coll_acc;
            r_coll_any <= |r_coll_acc;
            r_coll_acc <= w_coll;
            if ((r_coll_acc != '0) && (r_coll_cnt != '1)) begin
                r_coll_cnt <= r_coll_cnt + CNTW'(1);
            end
        end else begin
            r_coll_acc <= r_coll_acc | w_coll;
        end
    end

    assign coll_vec = r_coll_vec;
    assign coll_any = r_coll_any;
    assign coll_cnt = r_coll_cnt;
`else
    logic w_unused_frame;

    assign w_unused_frame = frame;
    assign coll_vec       = '0;
    assign coll_any       = 1'b0;
    assign coll_cnt       = '0;
`endif

endmodule

// File: tb/tb_sprite_mixer.sv
// Scoreboard bench for sprite_mixer: driver pushes model predictions, monitor pops and compares.
// Expected collision outputs follow SPRITE_MIXER_COLLIDE_EN for the build under test.
module tb_sprite_mixer;

    localparam int unsigned NSPR  = 4;
    localparam int unsigned CIDXW = 2;
    localparam int unsigned IDW   = 2;
    localparam int unsigned CNTW  = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame = 1'b0;
    logic             bright = 1'b0;
    logic [3:0]       spr_en = '0;
    logic [3:0]       spr_drawing = '0;
    logic [7:0]       spr_pix = '0;
    logic [1:0]       pix;
    logic             drawing;
    logic [1:0]       hit_id;
    logic [3:0]       coll_vec;
    logic             coll_any;
    logic [7:0]       coll_cnt;

    typedef struct {
        logic [1:0] pix;
        logic       drawing;
        logic [1:0] hit_id;
        logic [3:0] vec;
        logic       any;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic drv_rst_n = 1'b0;

    // Reference state: accumulator, reported vector and frame counter.
    logic [3:0] m_acc = '0;
    logic [3:0] m_vec = '0;
    int         m_cnt = 0;

`ifdef SPRITE_MIXER_COLLIDE_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    sprite_mixer #(.NSPR(NSPR), .CIDXW(CIDXW), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .frame(frame), .bright(bright),
        .spr_en(spr_en), .spr_drawing(spr_drawing), .spr_pix(spr_pix),
        .pix(pix), .drawing(drawing), .hit_id(hit_id),
        .coll_vec(coll_vec), .coll_any(coll_any), .coll_cnt(coll_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict the registered outputs produced by the edge that samples these inputs.
    task automatic model_step(input logic fr, input logic br, input logic [3:0] en,
                              input logic [3:0] drw, input logic [7:0] px);
        exp_t       e;
        logic [3:0] op;
        logic [3:0] coll;
        logic [7:0] pxv;
        e = '{pix: 2'd0, drawing: 1'b0, hit_id: 2'd0, vec: 4'd0, any: 1'b0, cnt: 8'd0};
        if (!rst_n) begin
            m_acc = '0;
            m_vec = '0;
            m_cnt = 0;
        end else begin
            pxv = px;
            op  = '0;
            for (int i = 0; i < 4; i++)
                op[i] = en[i] && drw[i] && br && (pxv[2*i +: 2] != 2'd0);
            for (int i = 0; i < 4; i++) begin
                if (op[i]) begin
                    e.pix     = pxv[2*i +: 2];
                    e.hit_id  = 2'(i);
                    e.drawing = 1'b1;
                    break;
                end
            end
            coll = ($countones(op) >= 2) ? op : 4'd0;
            if (fr) begin
                if (m_acc != 4'd0 && m_cnt < 255) m_cnt++;
                m_vec = m_acc;
                m_acc = coll;
            end else begin
                m_acc = m_acc | coll;
            end
            if (COLL) begin
                e.vec = m_vec;
                e.any = (m_vec != 4'd0);
                e.cnt = 8'(m_cnt);
            end
        end
        q.push_back(e);
    endtask

    // Drive one pixel at the falling edge; record the prediction at the sampling edge.
    task automatic apply(input logic fr, input logic br, input logic [3:0] en,
                         input logic [3:0] drw, input logic [7:0] px);
        @(negedge clk);
        rst_n       = drv_rst_n;
        frame       = fr;
        bright      = br;
        spr_en      = en;
        spr_drawing = drw;
        spr_pix     = px;
        @(posedge clk);
        model_step(fr, br, en, drw, px);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b1, 4'hF, 4'h0, 8'h00);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk("pix",      32'(pix),      32'(e.pix));
            chk("drawing",  32'(drawing),  32'(e.drawing));
            chk("hit_id",   32'(hit_id),   32'(e.hit_id));
            chk("coll_vec", 32'(coll_vec), 32'(e.vec));
            chk("coll_any", 32'(coll_any), 32'(e.any));
            chk("coll_cnt", 32'(coll_cnt), 32'(e.cnt));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with random inputs: outputs stay zero.
        drv_rst_n = 1'b0;
        for (int i = 0; i < 4; i++)
            apply(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
        drv_rst_n = 1'b1;
        idle(2);
        #3;
        chk("rst_pix", 32'(pix), 32'd0);
        chk("rst_drawing", 32'(drawing), 32'd0);

        // Priority: ch1 (pix 2) over ch3 (pix 1).
        apply(1'b0, 1'b1, 4'hF, 4'b1010, 8'b01_00_10_00);
        #3;
        chk("prio_pix", 32'(pix), 32'd2);
        chk("prio_drawing", 32'(drawing), 32'd1);
        chk("prio_hit", 32'(hit_id), 32'd1);

        // Transparency of ch0 index 0, then disabling ch2.
        apply(1'b0, 1'b1, 4'hF, 4'b0101, 8'b00_11_00_00);
        #3;
        chk("transp_pix", 32'(pix), 32'd3);
        chk("transp_hit", 32'(hit_id), 32'd2);
        apply(1'b0, 1'b1, 4'b1011, 4'b0101, 8'b00_11_00_00);
        #3;
        chk("en_pix", 32'(pix), 32'd0);
        chk("en_drawing", 32'(drawing), 32'd0);

        // Frame N: ch0/ch2 overlap for 5 pixels, ch1 alone elsewhere.
        apply(1'b1, 1'b1, 4'hF, 4'h0, 8'h00);
        for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 4'hF, 4'b0101, 8'b00_10_00_01);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 4'hF, 4'b0010, 8'b00_00_01_00);
        apply(1'b1, 1'b1, 4'hF, 4'h0, 8'h00);
        #3;
        chk("t4_vec", 32'(coll_vec), COLL ? 32'h5 : 32'h0);
        chk("t4_any", 32'(coll_any), COLL ? 32'd1 : 32'd0);
        chk("t4_cnt", 32'(coll_cnt), COLL ? 32'd1 : 32'd0);
        idle(4);
        apply(1'b1, 1'b1, 4'hF, 4'h0, 8'h00);
        #3;
        chk("clean_vec", 32'(coll_vec), 32'd0);
        chk("clean_cnt", 32'(coll_cnt), COLL ? 32'd1 : 32'd0);

        // Overlap on the pulse cycle belongs to the new frame.
        apply(1'b1, 1'b1, 4'hF, 4'b0011, 8'b00_00_01_01);
        #3;
        chk("edge_vec_old", 32'(coll_vec), 32'd0);
        idle(3);
        apply(1'b1, 1'b1, 4'hF, 4'h0, 8'h00);
        #3;
        chk("edge_vec_new", 32'(coll_vec), COLL ? 32'h3 : 32'h0);
        chk("edge_cnt", 32'(coll_cnt), COLL ? 32'd2 : 32'd0);

        // Overlap outside active video is ignored.
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b0, 4'hF, 4'b1111, 8'hFF);
        apply(1'b1, 1'b1, 4'hF, 4'h0, 8'h00);
        #3;
        chk("dark_pix", 32'(pix), 32'd0);
        idle(2);
        apply(1'b1, 1'b1, 4'hF, 4'h0, 8'h00);
        #3;
        chk("dark_vec", 32'(coll_vec), 32'd0);
        chk("dark_cnt", 32'(coll_cnt), COLL ? 32'd2 : 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++)
            apply(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) != 0),
                  4'($urandom), 4'($urandom), 8'($urandom));

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 4'hF, 4'b0110, 8'b00_01_10_00);
        #3;
        rst_n     = 1'b0;
        drv_rst_n = 1'b0;
        #1;
        chk("arst_pix", 32'(pix), 32'd0);
        chk("arst_drawing", 32'(drawing), 32'd0);
        chk("arst_vec", 32'(coll_vec), 32'd0);
        chk("arst_cnt", 32'(coll_cnt), 32'd0);
        apply(1'b0, 1'b1, 4'hF, 4'b0110, 8'b00_01_10_00);
        drv_rst_n = 1'b1;
        apply(1'b1, 1'b1, 4'hF, 4'h0, 8'h00);
        #3;
        chk("post_rst_vec", 32'(coll_vec), 32'd0);
        chk("post_rst_cnt", 32'(coll_cnt), 32'd0);

        // 300 colliding frames saturate the counter.
        for (int f = 0; f < 300; f++) begin
            apply(1'b0, 1'b1, 4'hF, 4'b1001, 8'b11_00_00_11);
            apply(1'b1, 1'b1, 4'hF, 4'h0, 8'h00);
        end
        #3;
        chk("sat_cnt", 32'(coll_cnt), COLL ? 32'd255 : 32'd0);

        @(posedge clk);
        #4;
        chk("drain", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
